// File: rtl/cpld_bank_clk_ctrl.sv
// cpld_bank_clk_ctrl
//   Downstream of the CPLD address decoder. Holds the shadow copies of the
//   paged-ROM select and B+ shadow-RAM registers. Also runs the fast/slow
//   clock handover: a host IO access moves the CPU onto the host-aligned
//   clock, stalls it until the host phase is synchronised, and then keeps
//   it slow for a programmable tail.
//
// Ports
//   cpu_phi2       CPU clock; all state changes on the rising edge
//   resetb         async active-low reset
//   cpu_vda        valid data address; qualifies every cycle
//   cpu_rnw        1 = read, 0 = write
//   cpu_data[7:0]  CPU write data
//   dec_io         address in the host IO pages (FC00-FEFF)
//   dec_rom_reg    paged-ROM select register hit
//   dec_shadow_reg shadow-RAM register hit
//   dec_fe4x       system VIA hit
//   host_sync      host 2 MHz phase aligned; a slow bus cycle may complete
//   slow_req       request the host-aligned clock
//   cycle_hold     drive RDY low (stall CPU)
//   rom_bank       current paged-ROM bank
//   ram_sel        romsel bit 7 (sideways RAM / ANDY select)
//   shadow_en      B+ shadow RAM enable
//   via_access     one-cycle pulse after a completed FE4x access
//   sync_err       sticky host_sync timeout flag
module cpld_bank_clk_ctrl #(
  parameter int HOLD_CYCLES  = 3,
  parameter int SYNC_TIMEOUT = 12,
  parameter int ROMSEL_W     = 4
) (
  input  logic                cpu_phi2,
  input  logic                resetb,
  input  logic                cpu_vda,
  input  logic                cpu_rnw,
  input  logic [7:0]          cpu_data,
  input  logic                dec_io,
  input  logic                dec_rom_reg,
  input  logic                dec_shadow_reg,
  input  logic                dec_fe4x,
  input  logic                host_sync,
  output logic                slow_req,
  output logic                cycle_hold,
  output logic [ROMSEL_W-1:0] rom_bank,
  output logic                ram_sel,
  output logic                shadow_en,
  output logic                via_access,
  output logic                sync_err
);

  typedef enum logic [1:0] {ST_FAST, ST_REQ, ST_SLOW} state_t;

  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES);
  localparam logic [3:0] SYNC_LD = 4'(SYNC_TIMEOUT);

  // Decoded bus cycle, resolved once and shared by the FSM and the registers.
  typedef struct packed {
    logic io;
    logic wr_rom;
    logic wr_shd;
    logic via;
  } bus_cyc_t;

  state_t     state, state_nx;
  logic [3:0] sync_cnt, sync_cnt_nx;
  logic [3:0] hold_cnt, hold_cnt_nx;
  logic       commit;
  logic       err_set;
  bus_cyc_t   cyc;

  // Only the low bank bits and bit 7 are stored; the rest of the data bus
  // is intentionally ignored.
  logic unused_data;
  assign unused_data = ^cpu_data;

  // Decode strobes are meaningless outside a qualified IO cycle.
  always_comb begin
    cyc        = '0;
    cyc.io     = cpu_vda & dec_io;
    cyc.wr_rom = cyc.io & ~cpu_rnw & dec_rom_reg;
    cyc.wr_shd = cyc.io & ~cpu_rnw & dec_shadow_reg;
    cyc.via    = cyc.io & dec_fe4x;
  end

  // Counters use "<= 1 -> leave" so that a load of N gives exactly N cycles
  // in the state, and a load of 0 behaves like 1 (first eligible cycle
  // leaves). Both counters are parked at 0 on exit, so they never wrap.
  always_comb begin
    state_nx    = state;
    sync_cnt_nx = sync_cnt;
    hold_cnt_nx = hold_cnt;
    slow_req    = 1'b0;
    cycle_hold  = 1'b0;
    commit      = 1'b0;
    err_set     = 1'b0;
    unique case (state)
      ST_FAST: begin
        // Stall from the very first cycle of the IO access; gated by reset
        // so RDY is released while reset is held.
        cycle_hold = cyc.io & resetb;
        if (cyc.io) begin
          state_nx    = ST_REQ;
          sync_cnt_nx = SYNC_LD;
        end
      end
      ST_REQ: begin
        slow_req   = 1'b1;
        cycle_hold = 1'b1;
        if (host_sync) begin
          state_nx    = ST_SLOW;
          sync_cnt_nx = '0;
        end else if (sync_cnt <= 4'd1) begin
          state_nx    = ST_SLOW;
          sync_cnt_nx = '0;
          err_set     = 1'b1;
        end else begin
          sync_cnt_nx = sync_cnt - 4'd1;
        end
      end
      ST_SLOW: begin
        slow_req = 1'b1;
        if (cyc.io) begin
          // Access completes this cycle; an access on the last tail cycle
          // simply re-arms the tail without going back through REQ.
          commit      = 1'b1;
          hold_cnt_nx = HOLD_LD;
        end else if (hold_cnt <= 4'd1) begin
          state_nx    = ST_FAST;
          hold_cnt_nx = '0;
        end else begin
          hold_cnt_nx = hold_cnt - 4'd1;
        end
      end
      default: begin
        state_nx    = ST_FAST;
        sync_cnt_nx = '0;
        hold_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge cpu_phi2 or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_FAST;
      sync_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      sync_cnt <= sync_cnt_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  // Shadow registers: written only on a completed (SLOW) write cycle.
  always_ff @(posedge cpu_phi2 or negedge resetb) begin
    if (!resetb) begin
      rom_bank   <= '0;
      ram_sel    <= 1'b0;
      shadow_en  <= 1'b0;
      via_access <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      if (commit && cyc.wr_rom) begin
        rom_bank <= cpu_data[ROMSEL_W-1:0];
        ram_sel  <= cpu_data[7];
      end
      if (commit && cyc.wr_shd)
        shadow_en <= cpu_data[7];
      via_access <= commit & cyc.via;
      if (err_set)
        sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpld_bank_clk_ctrl.sv
// Directed bench for cpld_bank_clk_ctrl. Each step drives one CPU cycle,
// queues the outputs expected in that cycle, and compares on the falling edge.
module tb_cpld_bank_clk_ctrl;

  logic       cpu_phi2, resetb;
  logic       cpu_vda, cpu_rnw;
  logic [7:0] cpu_data;
  logic       dec_io, dec_rom_reg, dec_shadow_reg, dec_fe4x, host_sync;
  logic       slow_req, cycle_hold, ram_sel, shadow_en, via_access, sync_err;
  logic [3:0] rom_bank;

  cpld_bank_clk_ctrl #(.HOLD_CYCLES(3), .SYNC_TIMEOUT(12), .ROMSEL_W(4)) dut (
    .cpu_phi2(cpu_phi2), .resetb(resetb), .cpu_vda(cpu_vda), .cpu_rnw(cpu_rnw),
    .cpu_data(cpu_data), .dec_io(dec_io), .dec_rom_reg(dec_rom_reg),
    .dec_shadow_reg(dec_shadow_reg), .dec_fe4x(dec_fe4x), .host_sync(host_sync),
    .slow_req(slow_req), .cycle_hold(cycle_hold), .rom_bank(rom_bank),
    .ram_sel(ram_sel), .shadow_en(shadow_en), .via_access(via_access),
    .sync_err(sync_err)
  );

  initial cpu_phi2 = 1'b0;
  always #5 cpu_phi2 = ~cpu_phi2;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  // {slow_req, cycle_hold, rom_bank, ram_sel, shadow_en, via_access, sync_err}
  function automatic logic [9:0] E(input logic sr, input logic ch, input logic [3:0] bk,
                                   input logic rs, input logic sh, input logic va,
                                   input logic er);
    return {sr, ch, bk, rs, sh, va, er};
  endfunction

  task automatic step(input logic vda, input logic rnw, input logic [7:0] d,
                      input logic io, input logic rom, input logic shd,
                      input logic fe, input logic sync, input logic [9:0] exp,
                      input string tag);
    sb_t        e;
    logic [9:0] obs;
    cpu_vda = vda; cpu_rnw = rnw; cpu_data = d; dec_io = io;
    dec_rom_reg = rom; dec_shadow_reg = shd; dec_fe4x = fe; host_sync = sync;
    sb.push_back('{tag, exp});
    @(negedge cpu_phi2);
    obs = {slow_req, cycle_hold, rom_bank, ram_sel, shadow_en, via_access, sync_err};
    e = sb.pop_front();
    total++;
    assert (obs === e.exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
    @(posedge cpu_phi2);
    #1;
  endtask

  // Plain non-IO read cycle
  task automatic idle(input logic [9:0] exp, input string tag);
    step(1, 1, 8'h00, 0, 0, 0, 0, 0, exp, tag);
  endtask

  initial begin
    resetb = 1'b0;
    cpu_vda = 0; cpu_rnw = 1; cpu_data = 0; dec_io = 0;
    dec_rom_reg = 0; dec_shadow_reg = 0; dec_fe4x = 0; host_sync = 0;
    @(posedge cpu_phi2); #1;
    step(0, 1, 8'h00, 0, 0, 0, 0, 0, E(0,0,4'h0,0,0,0,0), "reset");
    resetb = 1'b1;
    idle(E(0,0,4'h0,0,0,0,0), "fast_rd");

    // romsel write 0x8D, host_sync arrives in the second REQ cycle
    step(1, 0, 8'h8D, 1, 1, 0, 0, 0, E(0,1,4'h0,0,0,0,0), "rom_fast_hold");
    step(1, 0, 8'h8D, 1, 1, 0, 0, 0, E(1,1,4'h0,0,0,0,0), "rom_req1");
    step(1, 0, 8'h8D, 1, 1, 0, 0, 1, E(1,1,4'h0,0,0,0,0), "rom_req2");
    step(1, 0, 8'h8D, 1, 1, 0, 0, 1, E(1,0,4'h0,0,0,0,0), "rom_slow");
    idle(E(1,0,4'hD,1,0,0,0), "rom_tail1");
    idle(E(1,0,4'hD,1,0,0,0), "rom_tail2");
    idle(E(1,0,4'hD,1,0,0,0), "rom_tail3");
    idle(E(0,0,4'hD,1,0,0,0), "rom_back_fast");

    // shadow write 0x80 then read of the same register
    step(1, 0, 8'h80, 1, 0, 1, 0, 0, E(0,1,4'hD,1,0,0,0), "shd_fast_hold");
    step(1, 0, 8'h80, 1, 0, 1, 0, 1, E(1,1,4'hD,1,0,0,0), "shd_req");
    step(1, 0, 8'h80, 1, 0, 1, 0, 1, E(1,0,4'hD,1,0,0,0), "shd_slow_wr");
    step(1, 1, 8'h00, 1, 0, 1, 0, 0, E(1,0,4'hD,1,1,0,0), "shd_slow_rd");
    idle(E(1,0,4'hD,1,1,0,0), "shd_after_rd");
    idle(E(1,0,4'hD,1,1,0,0), "shd_tail2");
    idle(E(1,0,4'hD,1,1,0,0), "shd_tail3");
    idle(E(0,0,4'hD,1,1,0,0), "shd_back_fast");

    // FE4x read, second access on the last hold cycle, vda=0 ignored
    step(1, 1, 8'h00, 1, 0, 0, 1, 0, E(0,1,4'hD,1,1,0,0), "via_fast_hold");
    step(1, 1, 8'h00, 1, 0, 0, 1, 1, E(1,1,4'hD,1,1,0,0), "via_req");
    step(1, 1, 8'h00, 1, 0, 0, 1, 1, E(1,0,4'hD,1,1,0,0), "via_slow");
    idle(E(1,0,4'hD,1,1,1,0), "via_pulse1");
    idle(E(1,0,4'hD,1,1,0,0), "via_pulse1_end");
    step(1, 1, 8'h00, 1, 0, 0, 1, 0, E(1,0,4'hD,1,1,0,0), "via_last_hold_io");
    idle(E(1,0,4'hD,1,1,1,0), "via_pulse2_no_req");
    step(0, 0, 8'h05, 1, 1, 0, 0, 0, E(1,0,4'hD,1,1,0,0), "vda0_slow");
    idle(E(1,0,4'hD,1,1,0,0), "via_tail_last");
    step(0, 0, 8'h05, 1, 1, 0, 0, 0, E(0,0,4'hD,1,1,0,0), "vda0_fast");

    // host_sync never arrives; simultaneous rom+shadow write commits in SLOW
    step(1, 0, 8'h03, 1, 1, 1, 0, 0, E(0,1,4'hD,1,1,0,0), "to_fast_hold");
    for (int i = 1; i <= 12; i++)
      step(1, 0, 8'h03, 1, 1, 1, 0, 0, E(1,1,4'hD,1,1,0,0), $sformatf("to_req%0d", i));
    step(1, 0, 8'h03, 1, 1, 1, 0, 0, E(1,0,4'hD,1,1,0,1), "to_slow_err");
    idle(E(1,0,4'h3,0,0,0,1), "both_wr_tail1");
    idle(E(1,0,4'h3,0,0,0,1), "both_wr_tail2");
    idle(E(1,0,4'h3,0,0,0,1), "both_wr_tail3");
    idle(E(0,0,4'h3,0,0,0,1), "err_sticky1");
    idle(E(0,0,4'h3,0,0,0,1), "err_sticky2");
    resetb = 1'b0;
    idle(E(0,0,4'h0,0,0,0,0), "rst_pulse");
    resetb = 1'b1;

    // reset while in REQ with a pending romsel write
    step(1, 0, 8'h8D, 1, 1, 0, 0, 0, E(0,1,4'h0,0,0,0,0), "rr_fast_hold");
    step(1, 0, 8'h8D, 1, 1, 0, 0, 0, E(1,1,4'h0,0,0,0,0), "rr_req");
    resetb = 1'b0;
    step(1, 0, 8'h8D, 1, 1, 0, 0, 1, E(0,0,4'h0,0,0,0,0), "rr_in_reset");
    resetb = 1'b1;
    idle(E(0,0,4'h0,0,0,0,0), "rr_released");
    idle(E(0,0,4'h0,0,0,0,0), "rr_fast");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
